// File: rtl/dmux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with valid/ready on input and every output channel.
// Out-of-range selects are accepted and dropped, flagged by sel_err and counted in drop_cnt.
module dmux_stream_1ton #(
   parameter int D         = 8,
   parameter int N         = 8,
   parameter int S         = 3,
   parameter int ZERO_IDLE = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [D-1:0]   in_data,
   input  logic [S-1:0]   in_sel,
   output logic [N-1:0]   out_valid,
   input  logic [N-1:0]   out_ready,
   output logic [N*D-1:0] out_data,
   output logic           sel_err,
   output logic [7:0]     drop_cnt
);

   // One extra bit so that N == 2**S still fits in the comparison constant.
   localparam logic [S:0] NUM_CH = (S+1)'(N);

   logic [N-1:0]   r_valid;
   logic [N*D-1:0] r_data;
   logic           r_sel_err;
   logic [7:0]     r_drop_cnt;

   logic           w_in_range;
   logic [N-1:0]   w_hit;
   logic           w_blocked;
   logic           w_accept;
   logic           w_drop;
   logic [N-1:0]   w_load;
   logic [N-1:0]   w_drain;

   assign w_in_range = ({1'b0, in_sel} < NUM_CH);

   // Decode the select into a one-hot channel hit vector.
   always_comb begin
      w_hit = {N{1'b0}};
      for (int c = 0; c < N; c++) begin
         if (in_sel == S'(c)) begin
            w_hit[c] = w_in_range;
         end else begin
            w_hit[c] = 1'b0;
         end
      end
   end

   // A full target channel that is not draining this cycle stalls the input.
   always_comb begin
      w_blocked = |(w_hit & r_valid & ~out_ready);
      if (rst) begin
         in_ready = 1'b0;
      end else begin
         in_ready = ~w_blocked;
      end
   end

   assign w_accept = in_valid & in_ready;
   assign w_drop   = w_accept & ~w_in_range;
   assign w_load   = w_hit & {N{w_accept}};
   assign w_drain  = r_valid & out_ready;

   // Per-channel holding registers; a load wins over a same-cycle drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= {N{1'b0}};
         r_data  <= {(N*D){1'b0}};
      end else begin
         for (int c = 0; c < N; c++) begin
            if (w_load[c]) begin
               r_valid[c]       <= 1'b1;
               r_data[c*D +: D] <= in_data;
            end else if (w_drain[c]) begin
               r_valid[c] <= 1'b0;
               if (ZERO_IDLE != 0) begin
                  r_data[c*D +: D] <= {D{1'b0}};
               end
            end
         end
      end
   end

   // Drop reporting: one-cycle error pulse and saturating drop counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_err  <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else begin
         r_sel_err <= w_drop;
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign sel_err   = r_sel_err;
   assign drop_cnt  = r_drop_cnt;

endmodule
